// File: rtl/seven_seg_pkg.sv
// Segment pattern table shared by the BCD-to-7-segment encoder and the scan decoder.
package seven_seg_pkg;

  localparam logic [6:0] SEG_0 = 7'h3F;
  localparam logic [6:0] SEG_1 = 7'h06;
  localparam logic [6:0] SEG_2 = 7'h5B;
  localparam logic [6:0] SEG_3 = 7'h4F;
  localparam logic [6:0] SEG_4 = 7'h66;
  localparam logic [6:0] SEG_5 = 7'h6D;
  localparam logic [6:0] SEG_6 = 7'h7D;
  localparam logic [6:0] SEG_7 = 7'h07;
  localparam logic [6:0] SEG_8 = 7'h7F;
  localparam logic [6:0] SEG_9 = 7'h6F;

  localparam logic [3:0] BCD_INVALID = 4'hF;

  typedef struct packed {
    logic [3:0] bcd;
    logic       illegal;
  } seg_decode_t;

  // Encoder direction; non-BCD values blank the digit.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] bcd);
    logic [6:0] seg;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = '0;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seven_seg_scan_decoder_seg7_to_bcd.sv
// Combinational 7-segment to BCD decoder; only the exact table codes are legal.
module seg7_to_bcd
  import seven_seg_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] bcd_o,
  output logic       illegal_o
);

  always_comb begin
    bcd_o     = BCD_INVALID;
    illegal_o = 1'b1;
    case (seg_i)
      SEG_0:   begin bcd_o = 4'd0; illegal_o = 1'b0; end
      SEG_1:   begin bcd_o = 4'd1; illegal_o = 1'b0; end
      SEG_2:   begin bcd_o = 4'd2; illegal_o = 1'b0; end
      SEG_3:   begin bcd_o = 4'd3; illegal_o = 1'b0; end
      SEG_4:   begin bcd_o = 4'd4; illegal_o = 1'b0; end
      SEG_5:   begin bcd_o = 4'd5; illegal_o = 1'b0; end
      SEG_6:   begin bcd_o = 4'd6; illegal_o = 1'b0; end
      SEG_7:   begin bcd_o = 4'd7; illegal_o = 1'b0; end
      SEG_8:   begin bcd_o = 4'd8; illegal_o = 1'b0; end
      SEG_9:   begin bcd_o = 4'd9; illegal_o = 1'b0; end
      default: begin bcd_o = BCD_INVALID; illegal_o = 1'b1; end
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Reads a multiplexed 7-segment bus back into one BCD frame per full scan,
// presented on a valid/ready port with overrun reporting.
module seven_seg_scan_decoder
  import seven_seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    overrun
);

  localparam int unsigned CNT_W  = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned PAIR_W = 7 + NUM_DIGITS;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_CAP = CNT_W'(STABLE_CYCLES - 2);

  logic [6:0]              seg_s1_q, seg_s2_q;
  logic [NUM_DIGITS-1:0]   an_s1_q, an_s2_q;
  logic [PAIR_W-1:0]       pair_prev_q;
  logic [CNT_W-1:0]        stable_cnt_q, stable_cnt_d;
  logic [4*NUM_DIGITS-1:0] slot_q, slot_d;
  logic [NUM_DIGITS-1:0]   slot_err_q, slot_err_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    out_valid_q, out_valid_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   err_q, err_d;
  logic                    overrun_q, overrun_d;

  logic [PAIR_W-1:0] pair_w;
  logic              same_w;
  logic              capture_w;
  logic              frame_full_w;
  seg_decode_t       dec_w;

  seg7_to_bcd u_dec (
    .seg_i     (seg_s2_q),
    .bcd_o     (dec_w.bcd),
    .illegal_o (dec_w.illegal)
  );

  assign pair_w       = {seg_s2_q, an_s2_q};
  assign same_w       = (pair_w == pair_prev_q);
  // Counter passes CNT_CAP only once per stable run, so this fires exactly once.
  assign capture_w    = same_w && (stable_cnt_q == CNT_CAP) && $onehot(an_s2_q);
  assign frame_full_w = &seen_q;

  always_comb begin
    stable_cnt_d = stable_cnt_q;
    if (!same_w) begin
      stable_cnt_d = '0;
    end else if (stable_cnt_q != CNT_MAX) begin
      stable_cnt_d = stable_cnt_q + 1'b1;
    end
  end

  always_comb begin
    slot_d     = slot_q;
    slot_err_d = slot_err_q;
    seen_d     = frame_full_w ? '0 : seen_q;
    if (capture_w) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (an_s2_q[i]) begin
          slot_d[4*i +: 4] = dec_w.bcd;
          slot_err_d[i]    = dec_w.illegal;
          seen_d[i]        = 1'b1;
        end
      end
    end
  end

  // A completed frame may load in the same cycle the held one is accepted.
  always_comb begin
    out_valid_d = out_valid_q;
    bcd_d       = bcd_q;
    err_d       = err_q;
    overrun_d   = 1'b0;
    if (frame_full_w) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        bcd_d       = slot_q;
        err_d       = slot_err_q;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q     <= '0;
      seg_s2_q     <= '0;
      an_s1_q      <= '0;
      an_s2_q      <= '0;
      pair_prev_q  <= '0;
      stable_cnt_q <= '0;
      slot_q       <= '0;
      slot_err_q   <= '0;
      seen_q       <= '0;
      out_valid_q  <= 1'b0;
      bcd_q        <= '0;
      err_q        <= '0;
      overrun_q    <= 1'b0;
    end else begin
      seg_s1_q     <= seg_in;
      seg_s2_q     <= seg_s1_q;
      an_s1_q      <= an_in;
      an_s2_q      <= an_s1_q;
      pair_prev_q  <= pair_w;
      stable_cnt_q <= stable_cnt_d;
      slot_q       <= slot_d;
      slot_err_q   <= slot_err_d;
      seen_q       <= seen_d;
      out_valid_q  <= out_valid_d;
      bcd_q        <= bcd_d;
      err_q        <= err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign out_valid = out_valid_q;
  assign bcd_out   = bcd_q;
  assign digit_err = err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Directed bench for seven_seg_scan_decoder: decode, glitch, illegal code,
// backpressure/overrun, blanking and asynchronous reset scenarios.
module tb_seven_seg_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = '0;
  logic [3:0]  an_in = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [15:0] bcd_out;
  logic [3:0]  digit_err;
  logic        overrun;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  int unsigned acc_cnt = 0;
  int unsigned ovr_cnt = 0;
  int unsigned acc_base = 0;
  logic [15:0] acc_bcd = '0;
  logic [3:0]  acc_err = '0;

  seven_seg_scan_decoder #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .seg_in    (seg_in),
    .an_in     (an_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .bcd_out   (bcd_out),
    .digit_err (digit_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // Record accepted frames and overrun pulses, sampled mid-cycle.
  always @(negedge clk) begin
    #1;
    if (rst_n) begin
      if (out_valid && out_ready) begin
        acc_cnt <= acc_cnt + 1;
        acc_bcd <= bcd_out;
        acc_err <= digit_err;
      end
      if (overrun) ovr_cnt <= ovr_cnt + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic show(input logic [3:0] an, input logic [6:0] seg, input int cyc);
    @(negedge clk);
    an_in  = an;
    seg_in = seg;
    repeat (cyc - 1) @(negedge clk);
  endtask

  task automatic frame(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3);
    show(4'b0001, s0, 20);
    show(4'b0010, s1, 20);
    show(4'b0100, s2, 20);
    show(4'b1000, s3, 20);
  endtask

  task automatic settle(input int cyc);
    repeat (cyc) @(negedge clk);
    #2;
  endtask

  initial begin
    settle(3);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_bcd", 32'(bcd_out), 32'd0);
    check("reset_err", 32'(digit_err), 32'd0);
    check("reset_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Decode sweep: 9,7,1,0 on digits 0..3.
    out_ready = 1'b1;
    frame(7'h6F, 7'h07, 7'h06, 7'h3F);
    settle(5);
    check("sweep_count", acc_cnt, 32'd1);
    check("sweep_bcd", 32'(acc_bcd), 32'h0179);
    check("sweep_err", 32'(acc_err), 32'h0);
    check("sweep_valid_low", 32'(out_valid), 32'd0);

    // Glitch: seg 66 for 5 cycles on digit 0 must not be captured.
    show(4'b0010, 7'h4F, 20);
    show(4'b0100, 7'h5B, 20);
    show(4'b1000, 7'h06, 20);
    show(4'b0001, 7'h66, 5);
    show(4'b0001, 7'h6D, 20);
    settle(5);
    check("glitch_count", acc_cnt, 32'd2);
    check("glitch_bcd", 32'(acc_bcd), 32'h1235);

    // Illegal pattern 7C on digit 2, held under backpressure.
    out_ready = 1'b0;
    frame(7'h06, 7'h5B, 7'h7C, 7'h4F);
    settle(5);
    check("illegal_valid", 32'(out_valid), 32'd1);
    check("illegal_bcd", 32'(bcd_out), 32'h3F21);
    check("illegal_err", 32'(digit_err), 32'h4);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    settle(2);
    check("illegal_acc_bcd", 32'(acc_bcd), 32'h3F21);
    check("illegal_valid_low", 32'(out_valid), 32'd0);

    // Backpressure: 1234 held, 5678 dropped with one overrun pulse.
    frame(7'h66, 7'h4F, 7'h5B, 7'h06);
    settle(5);
    check("bp_valid", 32'(out_valid), 32'd1);
    check("bp_bcd", 32'(bcd_out), 32'h1234);
    check("bp_no_overrun", ovr_cnt, 32'd0);
    frame(7'h7F, 7'h07, 7'h7D, 7'h6D);
    settle(5);
    check("bp_overrun", ovr_cnt, 32'd1);
    check("bp_bcd_held", 32'(bcd_out), 32'h1234);
    check("bp_valid_held", 32'(out_valid), 32'd1);
    acc_base = acc_cnt;
    @(negedge clk);
    out_ready = 1'b1;
    settle(3);
    check("bp_acc_count", acc_cnt, acc_base + 1);
    check("bp_acc_bcd", 32'(acc_bcd), 32'h1234);
    check("bp_valid_low", 32'(out_valid), 32'd0);

    // Blanking and multi-hot enables mid-scan.
    acc_base = acc_cnt;
    show(4'b0001, 7'h7F, 20);
    show(4'b0010, 7'h6F, 20);
    show(4'b0000, 7'h3F, 20);
    show(4'b0011, 7'h06, 20);
    show(4'b0100, 7'h3F, 20);
    show(4'b1000, 7'h66, 20);
    settle(5);
    check("blank_count", acc_cnt, acc_base + 1);
    check("blank_bcd", 32'(acc_bcd), 32'h4098);
    check("blank_err", 32'(acc_err), 32'h0);
    check("blank_no_overrun", ovr_cnt, 32'd1);

    // Asynchronous reset with a held frame and a partial frame pending.
    out_ready = 1'b0;
    frame(7'h06, 7'h06, 7'h06, 7'h06);
    show(4'b0001, 7'h5B, 20);
    show(4'b0010, 7'h5B, 20);
    settle(1);
    check("pre_reset_valid", 32'(out_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("async_valid", 32'(out_valid), 32'd0);
    check("async_bcd", 32'(bcd_out), 32'd0);
    check("async_err", 32'(digit_err), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    acc_base = acc_cnt;
    show(4'b0100, 7'h4F, 20);
    show(4'b1000, 7'h66, 20);
    settle(5);
    check("post_reset_partial", acc_cnt, acc_base);
    check("post_reset_valid", 32'(out_valid), 32'd0);
    show(4'b0001, 7'h06, 20);
    show(4'b0010, 7'h5B, 20);
    settle(5);
    check("post_reset_count", acc_cnt, acc_base + 1);
    check("post_reset_bcd", 32'(acc_bcd), 32'h4321);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
